traffic_analyzer_axil_regs: RTL and testbench
=============================================

Name: traffic_analyzer_axil_regs

Overview:
AXI4-Lite responder (slave) giving the host register access to a GMII traffic analyzer core: control, 64-bit statistics counters, capture timestamp, captured frame size, and the captured frame buffer.
- Sits between the host AXI-Lite interconnect and the analyzer datapath.
- 64-bit values read tear-free through HI-word snapshot latching.
- FRAME_BUF is an auto-incrementing read port.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_BASEADDR, 32'h20000000, base of the 256-byte register window
FB_ADDR_WIDTH, 9, frame buffer word-address width

Ports:
clk  in  1  single clock; AXI and core share it
rst  in  1  synchronous reset, active-high
S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  32/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  32/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
pkts  in  64  received frame counter
octets  in  64  received octet counter
octets_idle  in  64  idle octet counter
ts_sec  in  48  last-frame timestamp, seconds
ts_nsec  in  30  last-frame timestamp, nanoseconds
frame_size  in  16  captured frame length, bytes
frame_captured  in  1  one-cycle pulse when a new frame has been stored
fb_rd_en  out  1  frame buffer read strobe
fb_rd_addr  out  FB_ADDR_WIDTH  frame buffer word address
fb_rd_data  in  32  frame buffer data, valid 1 cycle after fb_rd_en
ctrl_enable  out  1  CONTROL[0]
ctrl_clear  out  1  one-cycle pulse on a write of CONTROL[1]=1

Behaviour:
- Register map. Offset is addr[7:0] and addr[1:0] is ignored.
  - 0x00 CONTROL (RW)
  - 0x04 FRAME_SIZE (RO, zero-extended)
  - 0x08/0x0C PKTS_HI/LO
  - 0x10/0x14 OCTETS_HI/LO
  - 0x18/0x1C IDLE_HI/LO
  - 0x20/0x24 TS_SEC_HI/LO; HI carries sec[47:32] zero-extended
  - 0x28 TS_NSEC, zero-extended
  - 0x2C FRAME_BUF (RO, pop)
  - Other in-window offsets read 0 with OKAY.
- Window hit: addr[31:8]==C_BASEADDR[31:8]. On a miss, the response is SLVERR (2'b10), RDATA=0, writes ignored.
- Reset: all READY/VALID outputs 0, RDATA=0, RRESP=BRESP=0, ctrl_enable=0, ctrl_clear=0, fb_rd_en=0, fb_rd_addr=0, shadows=0.
- Write handshake:
  - Wait until AWVALID&WVALID are both high and BVALID=0.
  - Then AWREADY and WREADY pulse together for exactly 1 cycle and the register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID=1.
- CONTROL write:
  - WSTRB[0] gates bits [7:0]; other bytes are not stored.
  - Bit1 is not stored. Writing 1 to bit1 makes ctrl_clear=1 for the cycle after acceptance.
  - Reads return {31'b0, enable}.
- Writes to RO offsets: OKAY, no effect.
- Read handshake:
  - ARREADY pulses 1 cycle when ARVALID=1, no read is in flight and RVALID=0.
  - Fixed latency: accept at cycle T, RVALID=1 at T+2 with RDATA/RRESP, held until RREADY.
  - One read outstanding max.
- Snapshot rule:
  - Accepting a read of PKTS_HI, OCTETS_HI or IDLE_HI latches the full 64-bit input into that counter's shadow in cycle T.
  - The HI read returns shadow[63:32]; the LO read returns shadow[31:0] and does not relatch.
  - Accepting TS_SEC_HI latches ts_sec and ts_nsec together; TS_SEC_LO and TS_NSEC return the shadows.
  - LO read without a prior HI read returns the shadow value, which is 0 after reset.
- FRAME_BUF read:
  - fb_rd_en pulses in cycle T with the current fb_rd_addr; fb_rd_data is registered at T+1 and returned at T+2.
  - fb_rd_addr increments at T+1 and wraps from 2^FB_ADDR_WIDTH-1 to 0.
- fb_rd_addr reset to 0 on rst, on ctrl_clear, or on frame_captured.
- Simultaneous events:
  - Reset or clear coinciding with an increment: reset wins, fb_rd_addr=0.
  - Read and write channels run independently and can both complete in the same cycle.
  - A write to CONTROL and a read of CONTROL in the same cycle: the read returns the pre-write value.
- Reset mid-transaction: pending B/R responses are dropped, VALIDs forced to 0 on the next edge.

Test Plan:
- After reset, read PKTS_HI then PKTS_LO with pkts=0 -> RDATA 0, 0, RRESP=OKAY, RVALID exactly 2 cycles after ARREADY.
- pkts=64'h0000_0001_FFFF_FFFF; read HI; change pkts to 64'h0000_0002_0000_0000; read LO -> HI=1, LO=32'hFFFFFFFF (tear-free).
- Write CONTROL 32'h3 with WSTRB=4'hF, AWVALID and WVALID offset by 3 cycles -> single AW/W ready pulse, ctrl_enable=1, ctrl_clear high 1 cycle, CONTROL reads 1.
- Frame buffer preloaded with word i = 32'hA0000000+i; pulse frame_captured; 18 FRAME_BUF reads -> A0000000..A0000011, fb_rd_addr=18; FB_ADDR_WIDTH=2 with 5 reads -> fifth returns word 0.
- Read 0x30000000 and write 0x30000000 (outside window) -> RRESP=BRESP=2'b10, RDATA=0, CONTROL unchanged.
- Hold RREADY=0 for 10 cycles, then assert rst during RVALID -> RDATA stable while stalled, RVALID=0 after the reset edge, next read completes normally.

Source files
------------

// File: rtl/traffic_analyzer_axil_regs.sv
// AXI4-Lite register window for the GMII traffic analyzer: control, tear-free
// 64-bit statistics, capture timestamp/size and an auto-incrementing frame buffer port.
module traffic_analyzer_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] C_BASEADDR         = 32'h20000000,
    parameter int          FB_ADDR_WIDTH      = 9
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,

    input  logic [63:0]                       pkts,
    input  logic [63:0]                       octets,
    input  logic [63:0]                       octets_idle,
    input  logic [47:0]                       ts_sec,
    input  logic [29:0]                       ts_nsec,
    input  logic [15:0]                       frame_size,
    input  logic                              frame_captured,

    output logic                              fb_rd_en,
    output logic [FB_ADDR_WIDTH-1:0]          fb_rd_addr,
    input  logic [31:0]                       fb_rd_data,

    output logic                              ctrl_enable,
    output logic                              ctrl_clear
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] OFF_CONTROL    = 6'h00;
    localparam logic [5:0] OFF_FRAME_SIZE = 6'h01;
    localparam logic [5:0] OFF_PKTS_HI    = 6'h02;
    localparam logic [5:0] OFF_PKTS_LO    = 6'h03;
    localparam logic [5:0] OFF_OCTETS_HI  = 6'h04;
    localparam logic [5:0] OFF_OCTETS_LO  = 6'h05;
    localparam logic [5:0] OFF_IDLE_HI    = 6'h06;
    localparam logic [5:0] OFF_IDLE_LO    = 6'h07;
    localparam logic [5:0] OFF_TS_SEC_HI  = 6'h08;
    localparam logic [5:0] OFF_TS_SEC_LO  = 6'h09;
    localparam logic [5:0] OFF_TS_NSEC    = 6'h0A;
    localparam logic [5:0] OFF_FRAME_BUF  = 6'h0B;

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_FETCH, RD_RESP} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic        aw_hit;
    logic        ar_hit;
    logic [5:0]  aw_off;
    logic [5:0]  ar_off;

    logic [5:0]  rd_off;
    logic        rd_hit;
    logic        ctrl_snap;
    logic [31:0] rd_mux;

    logic [63:0] pkts_shadow;
    logic [63:0] octets_shadow;
    logic [63:0] idle_shadow;
    logic [47:0] ts_sec_shadow;
    logic [29:0] ts_nsec_shadow;

    logic        unused_bits;

    assign aw_hit = (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:8] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:8]);
    assign ar_hit = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:8] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:8]);
    assign aw_off = S_AXI_AWADDR[7:2];
    assign ar_off = S_AXI_ARADDR[7:2];

    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:2],
                           S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

    // Write channel: AW and W are taken together, then one B response is held until BREADY.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            ctrl_enable   <= 1'b0;
            ctrl_clear    <= 1'b0;
        end else begin
            ctrl_clear <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wr_state      <= WR_ACCEPT;
                    end
                end
                WR_ACCEPT: begin
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_WREADY  <= 1'b0;
                    S_AXI_BVALID  <= 1'b1;
                    S_AXI_BRESP   <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                    if (aw_hit && aw_off == OFF_CONTROL && S_AXI_WSTRB[0]) begin
                        ctrl_enable <= S_AXI_WDATA[0];
                        ctrl_clear  <= S_AXI_WDATA[1];
                    end
                    wr_state <= WR_RESP;
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read-data selection happens one cycle after acceptance, from the latched offset.
    always_comb begin
        rd_mux = 32'h0;
        case (rd_off)
            OFF_CONTROL:    rd_mux = {31'h0, ctrl_snap};
            OFF_FRAME_SIZE: rd_mux = {16'h0, frame_size};
            OFF_PKTS_HI:    rd_mux = pkts_shadow[63:32];
            OFF_PKTS_LO:    rd_mux = pkts_shadow[31:0];
            OFF_OCTETS_HI:  rd_mux = octets_shadow[63:32];
            OFF_OCTETS_LO:  rd_mux = octets_shadow[31:0];
            OFF_IDLE_HI:    rd_mux = idle_shadow[63:32];
            OFF_IDLE_LO:    rd_mux = idle_shadow[31:0];
            OFF_TS_SEC_HI:  rd_mux = {16'h0, ts_sec_shadow[47:32]};
            OFF_TS_SEC_LO:  rd_mux = ts_sec_shadow[31:0];
            OFF_TS_NSEC:    rd_mux = {2'b00, ts_nsec_shadow};
            OFF_FRAME_BUF:  rd_mux = fb_rd_data;
            default:        rd_mux = 32'h0;
        endcase
    end

    // Read channel: ARREADY in cycle T, shadows latch at T, RVALID with data at T+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state       <= RD_IDLE;
            S_AXI_ARREADY  <= 1'b0;
            S_AXI_RVALID   <= 1'b0;
            S_AXI_RDATA    <= '0;
            S_AXI_RRESP    <= RESP_OKAY;
            fb_rd_en       <= 1'b0;
            rd_off         <= 6'h0;
            rd_hit         <= 1'b0;
            ctrl_snap      <= 1'b0;
            pkts_shadow    <= 64'h0;
            octets_shadow  <= 64'h0;
            idle_shadow    <= 64'h0;
            ts_sec_shadow  <= 48'h0;
            ts_nsec_shadow <= 30'h0;
        end else begin
            fb_rd_en <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b1;
                        fb_rd_en      <= ar_hit && (ar_off == OFF_FRAME_BUF);
                        rd_state      <= RD_ACCEPT;
                    end
                end
                RD_ACCEPT: begin
                    S_AXI_ARREADY <= 1'b0;
                    rd_off        <= ar_off;
                    rd_hit        <= ar_hit;
                    // Sampled here so a same-cycle CONTROL write is not visible to this read.
                    ctrl_snap     <= ctrl_enable;
                    if (ar_hit) begin
                        case (ar_off)
                            OFF_PKTS_HI:   pkts_shadow   <= pkts;
                            OFF_OCTETS_HI: octets_shadow <= octets;
                            OFF_IDLE_HI:   idle_shadow   <= octets_idle;
                            OFF_TS_SEC_HI: begin
                                ts_sec_shadow  <= ts_sec;
                                ts_nsec_shadow <= ts_nsec;
                            end
                            default: ;
                        endcase
                    end
                    rd_state <= RD_FETCH;
                end
                RD_FETCH: begin
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RDATA  <= rd_hit ? rd_mux : 32'h0;
                    S_AXI_RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rd_state     <= RD_RESP;
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rd_state     <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Restarting the buffer pointer takes priority over a pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || ctrl_clear || frame_captured) begin
            fb_rd_addr <= '0;
        end else if (fb_rd_en) begin
            fb_rd_addr <= fb_rd_addr + {{(FB_ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_traffic_analyzer_axil_regs.sv
// Directed bench for traffic_analyzer_axil_regs; a second instance with a 4-word
// frame buffer shares all inputs to observe address wrap.
module tb_traffic_analyzer_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [63:0] pkts, octets, octets_idle;
    logic [47:0] ts_sec;
    logic [29:0] ts_nsec;
    logic [15:0] frame_size;
    logic        frame_captured;

    logic        awready, wready, bvalid, arready, rvalid, fb_rd_en, ctrl_enable, ctrl_clear;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [8:0]  fb_rd_addr;
    logic [31:0] fb_rd_data = 32'h0;

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_fb_rd_en, s_ctrl_enable, s_ctrl_clear;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [1:0]  s_fb_rd_addr;
    logic [31:0] s_fb_rd_data = 32'h0;

    logic [31:0] fb_mem [0:511];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_analyzer_axil_regs dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .pkts(pkts), .octets(octets), .octets_idle(octets_idle),
        .ts_sec(ts_sec), .ts_nsec(ts_nsec), .frame_size(frame_size), .frame_captured(frame_captured),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .ctrl_enable(ctrl_enable), .ctrl_clear(ctrl_clear)
    );

    traffic_analyzer_axil_regs #(.FB_ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(s_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(s_wready),
        .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(s_arready),
        .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(rready),
        .pkts(pkts), .octets(octets), .octets_idle(octets_idle),
        .ts_sec(ts_sec), .ts_nsec(ts_nsec), .frame_size(frame_size), .frame_captured(frame_captured),
        .fb_rd_en(s_fb_rd_en), .fb_rd_addr(s_fb_rd_addr), .fb_rd_data(s_fb_rd_data),
        .ctrl_enable(s_ctrl_enable), .ctrl_clear(s_ctrl_clear)
    );

    // Frame buffer RAM model: one-cycle registered read.
    always @(posedge clk) begin
        if (fb_rd_en)   fb_rd_data   <= fb_mem[fb_rd_addr];
        if (s_fb_rd_en) s_fb_rd_data <= fb_mem[{7'b0, s_fb_rd_addr}];
    end

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output logic [31:0] s_data);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) begin
            checks++; errors++;
            $display("[TB] FAIL ar_timeout addr=%h arready=%b required=1", addr, arready);
            arvalid = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11; lat = -1; s_data = 32'hDEAD_BEEF;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("[TB] FAIL r_timeout addr=%h rvalid=%b required=1", addr, rvalid);
        end
        data = rdata; resp = rresp; s_data = s_rdata;
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp,
                             output int aw_p, output int w_p, output int clr_p);
        bit hs_seen = 0;
        bit done = 0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        aw_p = 0; w_p = 0; clr_p = 0; resp = 2'b11;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (hs_seen) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (awready) aw_p++;
            if (wready) w_p++;
            if (ctrl_clear) clr_p++;
            if (awready && wready) hs_seen = 1;
            if (!hs_seen && k == aw_dly) awvalid = 1'b1;
            if (!hs_seen && k == w_dly) wvalid = 1'b1;
            if (bvalid) begin resp = bresp; done = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL b_timeout addr=%h bvalid=%b required=1", addr, bvalid);
        end
        repeat (3) begin
            @(negedge clk);
            if (awready) aw_p++;
            if (wready) w_p++;
            if (ctrl_clear) clr_p++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, sd;
        logic [1:0]  r;
        int          lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, fb_rd_en, ctrl_enable, ctrl_clear} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b required=00000000",
                     {awready, wready, bvalid, arready, rvalid, fb_rd_en, ctrl_enable, ctrl_clear});
        end
        checks++;
        if ({rdata, rresp, bresp, fb_rd_addr} !== 45'h0) begin
            errors++;
            $display("[TB] FAIL reset_values rdata=%h rresp=%b bresp=%b fb_rd_addr=%0d required all 0",
                     rdata, rresp, bresp, fb_rd_addr);
        end
        rst = 1'b0;
        axi_read(32'h2000_0008, d, r, lat, sd);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("[TB] FAIL pkts_hi_reset got=%h/%b required=00000000/00", d, r);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL read_latency got=%0d required=2", lat);
        end
        axi_read(32'h2000_000C, d, r, lat, sd);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("[TB] FAIL pkts_lo_reset got=%h/%b required=00000000/00", d, r);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] d, sd;
        logic [1:0]  r;
        int          lat;
        octets = 64'h1111_2222_3333_4444;
        axi_read(32'h2000_0014, d, r, lat, sd);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL octets_lo_no_hi got=%h required=00000000", d);
        end
        pkts = 64'h0000_0001_FFFF_FFFF;
        axi_read(32'h2000_0008, d, r, lat, sd);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("[TB] FAIL pkts_hi got=%h required=00000001", d);
        end
        pkts = 64'h0000_0002_0000_0000;
        axi_read(32'h2000_000C, d, r, lat, sd);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL pkts_lo_tearfree got=%h required=FFFFFFFF", d);
        end
        octets_idle = 64'hCAFE_0001_BEEF_0002;
        axi_read(32'h2000_0018, d, r, lat, sd);
        octets_idle = 64'h0;
        axi_read(32'h2000_001C, sd, r, lat, sd);
        checks++;
        if ({d, sd} !== 64'hCAFE_0001_BEEF_0002) begin
            errors++; $display("[TB] FAIL idle_pair got=%h required=CAFE0001BEEF0002", {d, sd});
        end
        ts_sec = 48'hABCD_1234_5678; ts_nsec = 30'h0123_4567;
        axi_read(32'h2000_0020, d, r, lat, sd);
        checks++;
        if (d !== 32'h0000_ABCD) begin
            errors++; $display("[TB] FAIL ts_sec_hi got=%h required=0000ABCD", d);
        end
        ts_sec = 48'h0; ts_nsec = 30'h0;
        axi_read(32'h2000_0024, d, r, lat, sd);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL ts_sec_lo got=%h required=12345678", d);
        end
        axi_read(32'h2000_0028, d, r, lat, sd);
        checks++;
        if (d !== 32'h0123_4567) begin
            errors++; $display("[TB] FAIL ts_nsec got=%h required=01234567", d);
        end
        axi_read(32'h2000_0004, d, r, lat, sd);
        checks++;
        if (d !== 32'h0000_05EE) begin
            errors++; $display("[TB] FAIL frame_size got=%h required=000005EE", d);
        end
    endtask

    task automatic test_control_write();
        logic [31:0] d, sd;
        logic [1:0]  r;
        int          lat, aw_p, w_p, clr_p;
        axi_write(32'h2000_0000, 32'h3, 4'hF, 0, 3, r, aw_p, w_p, clr_p);
        checks++;
        if (aw_p !== 1 || w_p !== 1) begin
            errors++; $display("[TB] FAIL ready_pulses aw=%0d w=%0d required=1/1", aw_p, w_p);
        end
        checks++;
        if (clr_p !== 1) begin
            errors++; $display("[TB] FAIL ctrl_clear_pulse got=%0d cycles required=1", clr_p);
        end
        checks++;
        if (r !== 2'b00 || ctrl_enable !== 1'b1) begin
            errors++; $display("[TB] FAIL ctrl_write bresp=%b enable=%b required=00/1", r, ctrl_enable);
        end
        axi_read(32'h2000_0000, d, r, lat, sd);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("[TB] FAIL control_read got=%h required=00000001", d);
        end
        axi_write(32'h2000_0000, 32'h0, 4'hE, 0, 0, r, aw_p, w_p, clr_p);
        checks++;
        if (ctrl_enable !== 1'b1) begin
            errors++; $display("[TB] FAIL wstrb_gate enable=%b required=1", ctrl_enable);
        end
        axi_write(32'h2000_0004, 32'hFFFF, 4'hF, 1, 0, r, aw_p, w_p, clr_p);
        axi_read(32'h2000_0004, d, r, lat, sd);
        checks++;
        if (d !== 32'h0000_05EE || r !== 2'b00) begin
            errors++; $display("[TB] FAIL ro_write got=%h/%b required=000005EE/00", d, r);
        end
    endtask

    task automatic test_frame_buf();
        logic [31:0] d, sd;
        logic [1:0]  r;
        int          lat;
        @(negedge clk); frame_captured = 1'b1;
        @(negedge clk); frame_captured = 1'b0;
        for (int i = 0; i < 18; i++) begin
            axi_read(32'h2000_002C, d, r, lat, sd);
            checks++;
            if (d !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("[TB] FAIL frame_buf[%0d] got=%h required=%h", i, d, 32'hA000_0000 + 32'(i));
            end
            if (i == 4) begin
                checks++;
                if (sd !== 32'hA000_0000) begin
                    errors++; $display("[TB] FAIL fb_wrap_fifth got=%h required=A0000000", sd);
                end
            end
        end
        checks++;
        if (fb_rd_addr !== 9'd18 || s_fb_rd_addr !== 2'd2) begin
            errors++; $display("[TB] FAIL fb_rd_addr got=%0d/%0d required=18/2", fb_rd_addr, s_fb_rd_addr);
        end
    endtask

    task automatic test_out_of_window();
        logic [31:0] d, sd;
        logic [1:0]  r;
        int          lat, aw_p, w_p, clr_p;
        axi_read(32'h3000_0000, d, r, lat, sd);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("[TB] FAIL read_miss got=%h/%b required=00000000/10", d, r);
        end
        axi_write(32'h3000_0000, 32'h0, 4'hF, 0, 0, r, aw_p, w_p, clr_p);
        checks++;
        if (r !== 2'b10 || ctrl_enable !== 1'b1) begin
            errors++; $display("[TB] FAIL write_miss bresp=%b enable=%b required=10/1", r, ctrl_enable);
        end
        axi_read(32'h2000_0040, d, r, lat, sd);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("[TB] FAIL unmapped got=%h/%b required=00000000/00", d, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, sd, held;
        logic [1:0]  r;
        int          lat, n, unstable;
        @(negedge clk);
        araddr = 32'h2000_0004; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        held = rdata;
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rvalid || rdata !== held) unstable++;
        end
        checks++;
        if (held !== 32'h0000_05EE || unstable !== 0) begin
            errors++; $display("[TB] FAIL stall_hold data=%h unstable=%0d required=000005EE/0", held, unstable);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || ctrl_enable !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid rvalid=%b enable=%b required=0/0", rvalid, ctrl_enable);
        end
        rst = 1'b0;
        axi_read(32'h2000_0004, d, r, lat, sd);
        checks++;
        if (d !== 32'h0000_05EE || r !== 2'b00 || lat !== 2) begin
            errors++; $display("[TB] FAIL after_reset_read got=%h/%b lat=%0d required=000005EE/00 lat=2", d, r, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) fb_mem[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 1'b1;
        araddr = '0; arvalid = 0; rready = 1'b1;
        pkts = '0; octets = '0; octets_idle = '0; ts_sec = '0; ts_nsec = '0;
        frame_size = 16'h05EE; frame_captured = 1'b0;
        test_reset();
        test_snapshot();
        test_control_write();
        test_frame_buf();
        test_out_of_window();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
